digi_pattern_source: RTL and testbench
======================================

Name: digi_pattern_source

Overview:
- Clocked digital stimulus source.
- Plays a programmable sequence of (level, duration) steps and drives a level bit plus an amplitude code.
- Sits directly upstream of the lumped Amp stage; out_code is the control value its vcvs input consumes in mixed-mode netlists.
- Replaces ad-hoc PWL sources for Qucs DigiSource-style schematics.

Parameters:
- DEPTH, 16: number of pattern entries; power of two, at least 2.
- DUR_W, 16: width of the per-entry duration field, in clock cycles.
- AMP_W, 8: width of out_code.
- INIT_LEVEL, 0: output level while idle and after reset.
- SLEW, 1: code step per cycle; used only with the optional feature.

Ports:
- clk  in  1  Clock; all state changes on the rising edge.
- rst_n  in  1  Reset; synchronous, active-low.
- wr_en  in  1  Pattern-memory write strobe.
- wr_addr  in  AW = clog2(DEPTH)  Entry index to write.
- wr_level  in  1  Level stored in the entry.
- wr_dur  in  DUR_W  Hold duration stored in the entry.
- wr_err  out  1  One-cycle pulse when a write is rejected.
- num_entries  in  AW+1  Active sequence length; sampled at start.
- loop  in  1  Repeat the sequence; sampled at start.
- start  in  1  Begin playback.
- stop  in  1  Abort playback.
- amp_hi  in  AMP_W  Code driven for level 1.
- amp_lo  in  AMP_W  Code driven for level 0.
- busy  out  1  High while playing.
- step_idx  out  AW  Index of the entry being played.
- out_bit  out  1  Current level.
- out_code  out  AMP_W  Amplitude code sent to the Amp stage.
- done  out  1  One-cycle pulse on normal completion.

Behaviour:
- Reset, applied on any clk edge with rst_n=0 including mid-playback:
  - State goes to IDLE; busy=0, done=0, wr_err=0, step_idx=0.
  - out_bit=INIT_LEVEL; out_code = amp_hi if INIT_LEVEL else amp_lo.
  - Pattern memory contents are retained. The memory is not reset, and reads before the first write are undefined.
- States are IDLE and PLAY.
- IDLE:
  - A write commits at the edge when wr_en=1.
  - start=1 with num_entries>0: latch num_entries and loop, load entry 0, go to PLAY. busy rises and out_bit shows entry 0 on the next cycle (latency 1).
  - start=1 with num_entries=0: stay IDLE, pulse done next cycle.
  - num_entries>DEPTH is clamped to DEPTH.
- PLAY:
  - Entry i is held for dur_i cycles; dur=0 is treated as 1.
  - A down-counter of width DUR_W is loaded with dur_i-1 when the entry starts.
  - When the counter reaches 0 with i<N-1: advance to i+1 on the following edge.
  - At i=N-1 with loop=1: wrap to entry 0 with no gap cycle.
  - At i=N-1 with loop=0: go to IDLE. busy falls, done pulses for 1 cycle, and outputs return to INIT_LEVEL in that same cycle.
  - stop=1 goes to IDLE on the next edge with INIT_LEVEL outputs and no done pulse.
  - stop and start asserted in the same cycle: stop wins.
  - start while busy is ignored.
  - wr_en while busy: write dropped, wr_err pulses next cycle.
- Write and start in the same IDLE cycle: the write commits first, so a start that reads entry 0 sees the new data.
- out_code changes:
  - Follows out_bit, selecting amp_hi or amp_lo.
  - amp_hi/amp_lo are sampled every cycle, so changes propagate with 1-cycle latency.
- Total playback cycles for a non-looping run equal the sum of max(dur_i,1).

Optional Feature:
- Macro: DIGI_SRC_RAMP_EN.
- Defined:
  - out_code moves from its current value toward the target code by SLEW per cycle, saturating exactly at the target with no overshoot.
  - out_bit still switches immediately.
  - Reset loads the INIT_LEVEL code directly, with no ramp.
  - Entries shorter than the ramp leave out_code at an intermediate value, and the ramp continues toward the new target.
- Undefined: out_code equals the target code in the same cycle out_bit changes, and the SLEW parameter has no effect.

Decomposition:
- Shared package digi_src_pkg holds:
  - State encoding: IDLE=0, PLAY=1.
  - The clog2-based AW constant function.
  - The entry record layout {level, dur}.
- One sub-module, digi_src_mem: DEPTH x (1+DUR_W) register file with one synchronous write port and one combinational read port.
- The FSM, duration counter and optional ramp stay in digi_pattern_source.

Test Plan:
- Basic playback:
  - Stimulus: write entries {1,3},{0,2},{1,0}, num_entries=3, loop=0, start.
  - Required: out_bit is 1,1,1,0,0,1 starting 1 cycle after start; done pulses on the 7th cycle; busy high for exactly 6 cycles.
- Loop and stop:
  - Stimulus: same pattern with loop=1, run 14 cycles, then assert stop.
  - Required: the period-6 sequence repeats with no gap; after stop, busy=0, out_bit=INIT_LEVEL, and done never pulses.
- Empty sequence and write guard:
  - Stimulus: start with num_entries=0; then, during a playback, assert wr_en.
  - Required: done pulses once and busy stays 0; wr_err pulses and a later readback shows memory unchanged.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 edge at step 2 of a loop run, with amp_hi=200, amp_lo=10, INIT_LEVEL=0.
  - Required: out_code=10, step_idx=0, busy=0; a new start replays from entry 0 using the retained memory.
- Counter extremes:
  - Stimulus: entry with dur=2^DUR_W-1, DEPTH entries, num_entries=DEPTH+3.
  - Required: the long entry is held exactly 65535 cycles; the length clamps to 16 and the step_idx wrap is correct.
- Ramp (DIGI_SRC_RAMP_EN, SLEW=4):
  - Stimulus: amp_lo=0, amp_hi=10, switch to level 1.
  - Required: out_code is 4, 8, 10, then 10.

Source files
------------

// File: rtl/digi_src_pkg.sv
// Shared definitions for the digital pattern source: state encoding, address
// width helper and the pattern-entry layout {level, dur} (level in the MSB).
package digi_src_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  function automatic int aw_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // An entry is {level, dur[dur_w-1:0]}.
  function automatic int entry_w(input int dur_w);
    return dur_w + 1;
  endfunction

endpackage

// File: rtl/digi_src_mem.sv
// Pattern register file: DEPTH entries, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module digi_src_mem
  import digi_src_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 17,
  localparam int AW   = aw_f(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/digi_pattern_source.sv
// Programmable (level, duration) stimulus source driving a level bit and an
// amplitude code. Define DIGI_SRC_RAMP_EN to slew out_code by SLEW per cycle.
//
//  state | meaning
//  IDLE  | outputs at INIT_LEVEL, pattern memory writable, waiting for start
//  PLAY  | holding entry step_idx until the duration counter hits zero
module digi_pattern_source
  import digi_src_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DUR_W      = 16,
  parameter int AMP_W      = 8,
  parameter bit INIT_LEVEL = 1'b0,
  parameter int SLEW       = 1,
  localparam int AW        = aw_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             wr_level,
  input  logic [DUR_W-1:0] wr_dur,
  output logic             wr_err,
  input  logic [AW:0]      num_entries,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic [AMP_W-1:0] amp_hi,
  input  logic [AMP_W-1:0] amp_lo,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             out_bit,
  output logic [AMP_W-1:0] out_code,
  output logic             done
);

  localparam int EW = entry_w(DUR_W);
  localparam logic [AMP_W-1:0] SLEW_C = AMP_W'(SLEW);

  state_e           state;
  logic [AW:0]      n_lat;
  logic             loop_lat;
  logic [DUR_W-1:0] cnt;

  logic             mem_we;
  logic [AW-1:0]    rd_addr;
  logic [EW-1:0]    mem_rdata;
  logic [EW-1:0]    rd_entry;
  logic             rd_level;
  logic [DUR_W-1:0] rd_dur;
  logic [DUR_W-1:0] dur_init;
  logic [AW:0]      num_clamped;
  logic             last, tc, go, adv, fin, lvl_nxt;
  logic [AMP_W-1:0] target, code_nxt;

  assign mem_we = wr_en && (state == IDLE);

  digi_src_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata ({wr_level, wr_dur}),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  assign last    = ({1'b0, step_idx} == (n_lat - 1'b1));
  assign tc      = (cnt == '0);
  assign rd_addr = (state == PLAY && !last) ? step_idx + 1'b1 : '0;

  // Bypass so a start in the same cycle as a write to the read slot sees the new entry.
  assign rd_entry = (mem_we && (wr_addr == rd_addr)) ? {wr_level, wr_dur} : mem_rdata;
  assign rd_level = rd_entry[DUR_W];
  assign rd_dur   = rd_entry[DUR_W-1:0];
  assign dur_init = (rd_dur == '0) ? '0 : rd_dur - 1'b1;

  assign num_clamped = (num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_entries;

  assign go  = (state == IDLE) && start && !stop && (num_entries != '0);
  assign adv = (state == PLAY) && !stop && tc;
  assign fin = adv && last && !loop_lat;

  always_comb begin
    lvl_nxt = out_bit;
    if (go || (adv && !fin))
      lvl_nxt = rd_level;
    else if ((state == PLAY) && (stop || fin))
      lvl_nxt = INIT_LEVEL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
      step_idx <= '0;
      out_bit  <= INIT_LEVEL;
      n_lat    <= '0;
      loop_lat <= 1'b0;
      cnt      <= '0;
    end else begin
      done    <= 1'b0;
      wr_err  <= 1'b0;
      out_bit <= lvl_nxt;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (num_entries == '0) begin
              done <= 1'b1;
            end else begin
              n_lat    <= num_clamped;
              loop_lat <= loop;
              step_idx <= '0;
              cnt      <= dur_init;
              busy     <= 1'b1;
              state    <= PLAY;
            end
          end
        end
        PLAY: begin
          wr_err <= wr_en;
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            step_idx <= '0;
          end else if (tc) begin
            if (last && !loop_lat) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              step_idx <= '0;
            end else begin
              step_idx <= rd_addr;
              cnt      <= dur_init;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign target = lvl_nxt ? amp_hi : amp_lo;

`ifdef DIGI_SRC_RAMP_EN
  // Move toward the target by SLEW, landing exactly on it.
  always_comb begin
    code_nxt = out_code;
    if (out_code < target)
      code_nxt = ((target - out_code) > SLEW_C) ? out_code + SLEW_C : target;
    else if (out_code > target)
      code_nxt = ((out_code - target) > SLEW_C) ? out_code - SLEW_C : target;
  end
`else
  logic [AMP_W-1:0] unused_slew;
  assign unused_slew = SLEW_C;
  assign code_nxt    = target;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) out_code <= INIT_LEVEL ? amp_hi : amp_lo;
    else        out_code <= code_nxt;
  end

endmodule

// File: tb/tb_digi_pattern_source.sv
// Directed bench for digi_pattern_source with an expected-sequence scoreboard.
module tb_digi_pattern_source;

  localparam int DEPTH = 16;
  localparam int DUR_W = 16;
  localparam int AMP_W = 8;
  localparam int AW    = 4;
  localparam int SLEW  = 4;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             wr_level;
  logic [DUR_W-1:0] wr_dur;
  logic             wr_err;
  logic [AW:0]      num_entries;
  logic             loop;
  logic             start;
  logic             stop;
  logic [AMP_W-1:0] amp_hi;
  logic [AMP_W-1:0] amp_lo;
  logic             busy;
  logic [AW-1:0]    step_idx;
  logic             out_bit;
  logic [AMP_W-1:0] out_code;
  logic             done;

  digi_pattern_source #(
    .DEPTH(DEPTH), .DUR_W(DUR_W), .AMP_W(AMP_W), .INIT_LEVEL(1'b0), .SLEW(SLEW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_level(wr_level),
    .wr_dur(wr_dur), .wr_err(wr_err), .num_entries(num_entries), .loop(loop),
    .start(start), .stop(stop), .amp_hi(amp_hi), .amp_lo(amp_lo), .busy(busy),
    .step_idx(step_idx), .out_bit(out_bit), .out_code(out_code), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic mdl_lvl [DEPTH];
  int   mdl_dur [DEPTH];

  typedef struct {
    logic lvl;
    int   idx;
  } exp_t;
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int total(input int n);
    int s = 0;
    for (int e = 0; e < n && e < DEPTH; e++) s += eff(mdl_dur[e]);
    return s;
  endfunction

  task automatic wr(input int a, input logic l, input int d);
    wr_addr  = AW'(a);
    wr_level = l;
    wr_dur   = DUR_W'(d);
    wr_en    = 1'b1;
    step();
    wr_en    = 1'b0;
    mdl_lvl[a] = l;
    mdl_dur[a] = d;
  endtask

  task automatic push_seq(input int n, input bit lp, input int ncyc);
    int ne = (n > DEPTH) ? DEPTH : n;
    int c  = 0;
    while (c < ncyc && ne > 0) begin
      for (int e = 0; e < ne && c < ncyc; e++)
        for (int k = 0; k < eff(mdl_dur[e]) && c < ncyc; k++) begin
          sb.push_back('{mdl_lvl[e], e});
          c++;
        end
      if (!lp) break;
    end
  endtask

  task automatic run_play(input int n, input bit lp, input int ncyc);
    exp_t e;
    num_entries = (AW+1)'(n);
    loop        = lp;
    start       = 1'b1;
    step();
    start       = 1'b0;
    wr_en       = 1'b0;
    push_seq(n, lp, ncyc);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("play_bit", 32'(out_bit), 32'(e.lvl));
      chk("play_idx", 32'(step_idx), 32'(e.idx));
      chk("play_busy", 32'(busy), 32'd1);
      chk("play_done", 32'(done), 32'd0);
`ifndef DIGI_SRC_RAMP_EN
      chk("play_code", 32'(out_code), e.lvl ? 32'(amp_hi) : 32'(amp_lo));
`endif
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_level = 1'b0; wr_dur = '0;
    num_entries = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    amp_hi = 8'd200; amp_lo = 8'd10;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_idx", 32'(step_idx), 32'd0);
    chk("rst_bit", 32'(out_bit), 32'd0);
    chk("rst_code", 32'(out_code), 32'd10);
    rst_n = 1'b1;
    step();

    // Basic non-looping playback
    wr(0, 1'b1, 3);
    wr(1, 1'b0, 2);
    wr(2, 1'b1, 0);
    run_play(3, 1'b0, total(3));
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy", 32'(busy), 32'd0);
    chk("basic_bit", 32'(out_bit), 32'd0);
    chk("basic_code", 32'(out_code), 32'd10);
    step();
    chk("basic_done_pulse", 32'(done), 32'd0);

    // Looping run then stop together with start
    run_play(3, 1'b1, 14);
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_bit", 32'(out_bit), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    chk("stop_idx", 32'(step_idx), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stop_no_done", 32'(done), 32'd0);
      chk("stop_idle", 32'(busy), 32'd0);
    end

    // Empty sequence
    num_entries = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    step();
    chk("empty_done_pulse", 32'(done), 32'd0);
    chk("empty_busy2", 32'(busy), 32'd0);

    // Write while busy is rejected
    run_play(3, 1'b1, 2);
    wr_addr = '0; wr_level = 1'b0; wr_dur = 16'd9; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    chk("wr_err_pulse", 32'(wr_err), 32'd1);
    chk("wr_err_busy", 32'(busy), 32'd1);
    step();
    chk("wr_err_clear", 32'(wr_err), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("guard_stopped", 32'(busy), 32'd0);
    run_play(3, 1'b0, total(3));
    chk("readback_done", 32'(done), 32'd1);
    step();

    // Write and start in the same idle cycle
    wr_addr = '0; wr_level = 1'b0; wr_dur = 16'd2; wr_en = 1'b1;
    mdl_lvl[0] = 1'b0;
    mdl_dur[0] = 2;
    run_play(1, 1'b0, total(1));
    chk("wrstart_done", 32'(done), 32'd1);
    chk("wrstart_busy", 32'(busy), 32'd0);
    step();
    wr(0, 1'b1, 3);

    // Reset in the middle of a looping run
    run_play(3, 1'b1, 5);
    chk("mid_idx", 32'(step_idx), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_code", 32'(out_code), 32'd10);
    chk("mid_rst_idx", 32'(step_idx), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bit", 32'(out_bit), 32'd0);
    run_play(3, 1'b0, total(3));
    chk("mid_replay_done", 32'(done), 32'd1);
    step();

`ifndef DIGI_SRC_RAMP_EN
    // Amplitude inputs propagate with one cycle of latency
    amp_lo = 8'd33;
    chk("amp_before", 32'(out_code), 32'd10);
    step();
    chk("amp_after", 32'(out_code), 32'd33);
    amp_lo = 8'd10;
    step();
`endif

    // Counter extremes: max duration, full depth, clamped length
    wr(0, 1'b1, 65535);
    for (int i = 1; i < DEPTH; i++) wr(i, logic'((i % 2) == 0), i % 3);
    run_play(DEPTH + 3, 1'b1, total(DEPTH) + 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("extreme_stopped", 32'(busy), 32'd0);

`ifdef DIGI_SRC_RAMP_EN
    // Ramp toward amp_hi in SLEW steps
    amp_lo = 8'd0;
    amp_hi = 8'd10;
    rst_n  = 1'b0;
    step();
    rst_n  = 1'b1;
    chk("ramp_rst", 32'(out_code), 32'd0);
    wr(0, 1'b1, 10);
    num_entries = 5'd1;
    loop  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ramp_bit", 32'(out_bit), 32'd1);
    chk("ramp_1", 32'(out_code), 32'd4);
    step();
    chk("ramp_2", 32'(out_code), 32'd8);
    step();
    chk("ramp_3", 32'(out_code), 32'd10);
    step();
    chk("ramp_4", 32'(out_code), 32'd10);
    stop = 1'b1;
    step();
    stop = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
